// File: rtl/nr_divider_seq.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock through a
// single add/subtract stage, followed by one remainder-correction cycle.

module AddSub #(
    parameter int width = 9
) (
    input  logic [width-1:0] X,
    input  logic [width-1:0] Y,
    input  logic             SubEn,
    output logic [width-1:0] Sum
);
    // Subtraction as X + ~Y + 1; the carry out of the top bit is dropped.
    assign Sum = X + (SubEn ? ~Y : Y) + {{(width-1){1'b0}}, SubEn};
endmodule

module nr_divider_seq #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [width-1:0] Q,
    output logic [width-1:0] R,
    output logic             DivZero
);
    localparam int CW = (width > 2) ? $clog2(width) : 1;
    localparam logic [CW-1:0] lastCnt = CW'(width - 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t          state, nextState;
    logic [width:0]  P;
    logic [width-1:0] D;
    logic [width-1:0] QR;
    logic [CW-1:0]   cnt;

    logic [width:0]  addX, addY, addSum;
    logic            subEn;

    AddSub #(.width(width + 1)) uAddSub (
        .X     (addX),
        .Y     (addY),
        .SubEn (subEn),
        .Sum   (addSum)
    );

    // The same stage serves the shift-and-add/subtract step and the final P + D fix-up.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        addX  = {P[width-1:0], QR[width-1]};
        addY  = {1'b0, D};
        subEn = ~P[width];
        if (state == FIX) begin
            addX  = P;
            subEn = 1'b0;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start && (B != '0)) nextState = ITER;
            ITER:    if (cnt == lastCnt) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P       <= '0;
            D       <= '0;
            QR      <= '0;
            cnt     <= '0;
            Q       <= '0;
            R       <= '0;
            DivZero <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (B != '0) begin
                            D   <= B;
                            P   <= '0;
                            QR  <= A;
                            cnt <= '0;
                        end else begin
                            Q       <= '1;
                            R       <= A;
                            DivZero <= 1'b1;
                            Done    <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    P   <= addSum;
                    QR  <= {QR[width-2:0], ~addSum[width]};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (P[width]) P <= addSum;
                    Q       <= QR;
                    R       <= P[width] ? addSum[width-1:0] : P[width-1:0];
                    DivZero <= 1'b0;
                    Done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != IDLE);
endmodule
